sign_compress_tx: RTL and testbench
===================================

// Module: sign_compress_tx
// PURPOSE
//  Transmit side of the 16->32 immediate/data sign-extension path. Accepts 32-bit
//  words and sends them over a 16-bit link. A word that equals the sign extension
//  of its low half goes as one short beat; the receiver restores it by sign-extending.
//  Any other word goes as two beats, low half first. Sits between the datapath and
//  the narrow operand/immediate link.
// PARAMETERS
//  IN_W    32  input word width; must equal 2*OUT_W
//  OUT_W   16  link beat width
// PORTS
//  clk_i          in   1      rising-edge clock
//  rst_i          in   1      async reset, active-high
//  word_valid_i   in   1      input word valid
//  word_ready_o   out  1      block can take a word (high only in IDLE)
//  word_i         in   IN_W   input word
//  half_valid_o   out  1      link beat valid
//  half_ready_i   in   1      link sink ready
//  half_o         out  OUT_W  link beat data
//  half_short_o   out  1      beat is a short (sign-extendable) word; held for both beats
//  half_last_o    out  1      final beat of the current word
// BEHAVIOUR
//  - Reset: state=IDLE, word buffer=0, word_ready_o=1, half_valid_o=0, half_o=0,
//    half_short_o=0, half_last_o=0. All outputs are registered except word_ready_o,
//    which is decoded from state.
//  - A handshake occurs when valid && ready are both high on a rising edge.
//  - IDLE: word_ready_o=1. On a word handshake: latch word_i into wbuf, set
//    fits = (word_i[IN_W-1:OUT_W] == {OUT_W{word_i[OUT_W-1]}}), go to SEND_LO.
//  - SEND_LO: half_valid_o=1, half_o=wbuf[OUT_W-1:0], half_short_o=fits,
//    half_last_o=fits. On a beat handshake: if fits, go to IDLE; otherwise go to SEND_HI.
//  - SEND_HI: half_valid_o=1, half_o=wbuf[IN_W-1:OUT_W], half_short_o=0,
//    half_last_o=1. On a beat handshake, go to IDLE.
//  - Latency: first beat is valid in the cycle after the word handshake.
//    Throughput: a short word every 2 cycles, a long word every 3 cycles.
//  - Backpressure: while half_ready_i=0, half_valid_o and all beat outputs hold stable.
//    half_valid_o never drops before its handshake.
//  - Boundary values: 0x00007FFF and 0xFFFF8000 are short. 0x00008000 and
//    0xFFFF7FFF are long. 0x00000000 and 0xFFFFFFFF are short.
//  - word_valid_i is ignored outside IDLE. No input word is lost, because
//    word_ready_o=0 outside IDLE.
//  - Reset asserted mid-word: the pending word is dropped and all outputs return to
//    their reset values immediately (asynchronously). No partial beat is resent.
// CONFIGURATION
//  SIGN_COMPRESS_STATS_EN defined:
//    adds ports cnt_short_o and cnt_long_o, each an output, 16 bits wide.
//    Each counter increments by 1 at the last-beat handshake of a short or long
//    word respectively. Both reset to 0 and wrap from 0xFFFF to 0x0000 without a flag.
//  SIGN_COMPRESS_STATS_EN undefined:
//    these ports and counters do not exist. Behaviour is otherwise identical.
// TESTING
//  1 Reset, then send word 0x00001234 with half_ready_i=1
//    -> one beat: half_o=0x1234, short=1, last=1; word_ready_o high again 2 cycles after accept.
//  2 Send word 0xFFFF8000
//    -> one beat: half_o=0x8000, short=1, last=1.
//    Send word 0x00008000
//    -> beats 0x8000 (short=0, last=0) then 0x0000 (last=1).
//  3 Send word 0x12345678 with half_ready_i low for 3 cycles in SEND_LO
//    -> half_o holds 0x5678 and valid stays high; then 0x1234 follows with last=1.
//  4 Hold word_valid_i=1 with 0xDEADBEEF during SEND_HI of a previous word
//    -> it is accepted only in IDLE; beats are 0xBEEF then 0xDEAD.
//  5 Assert rst_i during SEND_HI
//    -> half_valid_o=0 at once; after release, state is IDLE and word_ready_o=1.
//  6 With SIGN_COMPRESS_STATS_EN: send 3 short words and 2 long words
//    -> cnt_short_o=3, cnt_long_o=2. Preload cnt_short_o to 0xFFFF, send 1 short word
//    -> cnt_short_o=0x0000.

Source files
------------

// File: rtl/sign_compress_tx.sv
// Sends 32-bit words over a 16-bit link: a sign-extendable word goes as one short beat, any other word as low then high half.
// Optional SIGN_COMPRESS_STATS_EN adds short/long word counters (cnt_short_o, cnt_long_o).
module sign_compress_tx #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             word_valid_i,
    output logic             word_ready_o,
    input  logic [IN_W-1:0]  word_i,
    output logic             half_valid_o,
    input  logic             half_ready_i,
    output logic [OUT_W-1:0] half_o,
    output logic             half_short_o,
    output logic             half_last_o
`ifdef SIGN_COMPRESS_STATS_EN
    ,
    output logic [15:0]      cnt_short_o,
    output logic [15:0]      cnt_long_o
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND_LO = 2'd1,
        SEND_HI = 2'd2
    } state_t;

    state_t          state;
    logic [IN_W-1:0] wbuf;
    logic            fits;
    logic            fits_in;
    logic            beat_done;

    // The upper half is pure sign fill, so the receiver can rebuild the word from the low half.
    assign fits_in      = (word_i[IN_W-1:OUT_W] == {OUT_W{word_i[OUT_W-1]}});
    assign word_ready_o = (state == IDLE);
    assign beat_done    = half_valid_o && half_ready_i;

    // NOTE: all state and outputs use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            wbuf         <= '0;
            fits         <= 1'b0;
            half_valid_o <= 1'b0;
            half_o       <= '0;
            half_short_o <= 1'b0;
            half_last_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (word_valid_i) begin
                        wbuf         <= word_i;
                        fits         <= fits_in;
                        state        <= SEND_LO;
                        half_valid_o <= 1'b1;
                        half_o       <= word_i[OUT_W-1:0];
                        half_short_o <= fits_in;
                        half_last_o  <= fits_in;
                    end
                end
                SEND_LO: begin
                    if (beat_done) begin
                        if (fits) begin
                            state        <= IDLE;
                            half_valid_o <= 1'b0;
                            half_short_o <= 1'b0;
                            half_last_o  <= 1'b0;
                        end else begin
                            state        <= SEND_HI;
                            half_o       <= wbuf[IN_W-1:OUT_W];
                            half_short_o <= 1'b0;
                            half_last_o  <= 1'b1;
                        end
                    end
                end
                SEND_HI: begin
                    if (beat_done) begin
                        state        <= IDLE;
                        half_valid_o <= 1'b0;
                        half_short_o <= 1'b0;
                        half_last_o  <= 1'b0;
                    end
                end
                default: begin
                    state        <= IDLE;
                    half_valid_o <= 1'b0;
                end
            endcase
        end
    end

`ifdef SIGN_COMPRESS_STATS_EN
    logic [15:0] cnt_short_q;
    logic [15:0] cnt_long_q;

    // The last beat's short flag tells which kind of word just completed; counters wrap silently.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_short_q <= '0;
            cnt_long_q  <= '0;
        end else if (beat_done && half_last_o) begin
            if (half_short_o) cnt_short_q <= cnt_short_q + 16'd1;
            else              cnt_long_q  <= cnt_long_q + 16'd1;
        end
    end

    assign cnt_short_o = cnt_short_q;
    assign cnt_long_o  = cnt_long_q;
`endif

endmodule

// File: tb/tb_sign_compress_tx.sv
// Self-checking bench for sign_compress_tx: table of words with known short/long class, scoreboard of expected beats.
module tb_sign_compress_tx;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        word_valid_i;
    logic        word_ready_o;
    logic [31:0] word_i;
    logic        half_valid_o;
    logic        half_ready_i;
    logic [15:0] half_o;
    logic        half_short_o;
    logic        half_last_o;
`ifdef SIGN_COMPRESS_STATS_EN
    logic [15:0] cnt_short_o;
    logic [15:0] cnt_long_o;
`endif

    sign_compress_tx #(.IN_W(32), .OUT_W(16)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .word_valid_i (word_valid_i),
        .word_ready_o (word_ready_o),
        .word_i       (word_i),
        .half_valid_o (half_valid_o),
        .half_ready_i (half_ready_i),
        .half_o       (half_o),
        .half_short_o (half_short_o),
        .half_last_o  (half_last_o)
`ifdef SIGN_COMPRESS_STATS_EN
        ,
        .cnt_short_o  (cnt_short_o),
        .cnt_long_o   (cnt_long_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [15:0] data;
        logic        short_f;
        logic        last;
    } beat_t;

    typedef struct {
        logic [31:0] word;
        bit          is_short;
    } vec_t;

    beat_t exp_q[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    exp_short_cnt = 0;
    int    exp_long_cnt = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: handshakes are seen at the negedge before the rising edge that completes them.
    logic        stall_seen = 1'b0;
    logic [15:0] stall_data;
    logic        stall_last;
    always @(negedge clk_i) begin
        if (rst_i) begin
            stall_seen = 1'b0;
        end else begin
            if (stall_seen) begin
                check("stall_valid_hold", {31'd0, half_valid_o}, 32'd1);
                check("stall_data_hold", {16'd0, half_o}, {16'd0, stall_data});
                check("stall_last_hold", {31'd0, half_last_o}, {31'd0, stall_last});
            end
            stall_seen = half_valid_o && !half_ready_i;
            stall_data = half_o;
            stall_last = half_last_o;
            if (half_valid_o && half_ready_i) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", {16'd0, half_o}, 32'hFFFF_FFFF);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("beat_data", {16'd0, half_o}, {16'd0, e.data});
                    check("beat_short", {31'd0, half_short_o}, {31'd0, e.short_f});
                    check("beat_last", {31'd0, half_last_o}, {31'd0, e.last});
                end
            end
        end
    end

    task automatic push_word(input logic [31:0] w, input bit is_short);
        beat_t b;
        b.data = w[15:0]; b.short_f = is_short; b.last = is_short;
        exp_q.push_back(b);
        if (!is_short) begin
            b.data = w[31:16]; b.short_f = 1'b0; b.last = 1'b1;
            exp_q.push_back(b);
            exp_long_cnt++;
        end else begin
            exp_short_cnt++;
        end
    endtask

    // Offers a word and returns at #1 after the accepting edge.
    task automatic send_word(input logic [31:0] w, input bit is_short);
        bit accepted = 1'b0;
        push_word(w, is_short);
        word_i       = w;
        word_valid_i = 1'b1;
        for (int i = 0; i < 50 && !accepted; i++) begin
            @(negedge clk_i);
            accepted = word_ready_o;
            @(posedge clk_i);
            #1;
        end
        word_valid_i = 1'b0;
        check("accept_timeout", {31'd0, accepted}, 32'd1);
    endtask

    task automatic drain();
        int i = 0;
        while ((exp_q.size() != 0 || half_valid_o) && i < 100) begin
            @(posedge clk_i);
            #1;
            i++;
        end
        check("drain_timeout", {31'd0, (exp_q.size() == 0 && !half_valid_o)}, 32'd1);
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{32'h0000_1234, 1'b1};
        vecs[1] = '{32'hFFFF_8000, 1'b1};
        vecs[2] = '{32'h0000_8000, 1'b0};
        vecs[3] = '{32'h0000_7FFF, 1'b1};
        vecs[4] = '{32'hFFFF_7FFF, 1'b0};
        vecs[5] = '{32'h0000_0000, 1'b1};
        vecs[6] = '{32'hFFFF_FFFF, 1'b1};
        vecs[7] = '{32'h1234_5678, 1'b0};

        rst_i        = 1'b1;
        word_valid_i = 1'b0;
        word_i       = '0;
        half_ready_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_word_ready", {31'd0, word_ready_o}, 32'd1);
        check("rst_half_valid", {31'd0, half_valid_o}, 32'd0);
        check("rst_half_o", {16'd0, half_o}, 32'd0);
        check("rst_half_short", {31'd0, half_short_o}, 32'd0);
        check("rst_half_last", {31'd0, half_last_o}, 32'd0);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        // Short word: beat valid the cycle after accept, ready again one cycle later.
        send_word(32'h0000_1234, 1'b1);
        check("t1_valid_after_accept", {31'd0, half_valid_o}, 32'd1);
        check("t1_busy_after_accept", {31'd0, word_ready_o}, 32'd0);
        @(posedge clk_i);
        #1;
        check("t1_ready_again", {31'd0, word_ready_o}, 32'd1);
        drain();

        // Table of boundary and typical words, offered back to back.
        for (int i = 0; i < 8; i++) send_word(vecs[i].word, vecs[i].is_short);
        drain();

        // Backpressure in SEND_LO for 3 cycles.
        half_ready_i = 1'b0;
        send_word(32'h1234_5678, 1'b0);
        repeat (3) @(posedge clk_i);
        #1;
        check("t3_hold_valid", {31'd0, half_valid_o}, 32'd1);
        check("t3_hold_data", {16'd0, half_o}, 32'h0000_5678);
        half_ready_i = 1'b1;
        drain();

        // Word offered during SEND_HI must wait for IDLE.
        send_word(32'hCAFE_F00D, 1'b0);
        @(posedge clk_i);
        #1;
        half_ready_i = 1'b0;
        word_i       = 32'hDEAD_BEEF;
        word_valid_i = 1'b1;
        repeat (3) begin
            @(posedge clk_i);
            #1;
            check("t4_not_ready_in_hi", {31'd0, word_ready_o}, 32'd0);
        end
        check("t4_hi_data", {16'd0, half_o}, 32'h0000_CAFE);
        half_ready_i = 1'b1;
        send_word(32'hDEAD_BEEF, 1'b0);
        drain();

        // Reset during SEND_HI drops the word at once.
        send_word(32'h8765_4321, 1'b0);
        @(posedge clk_i);
        #1;
        half_ready_i = 1'b0;
        check("t5_in_hi_last", {31'd0, half_last_o}, 32'd1);
        rst_i = 1'b1;
        #1;
        check("t5_async_valid", {31'd0, half_valid_o}, 32'd0);
        check("t5_async_half_o", {16'd0, half_o}, 32'd0);
        check("t5_async_last", {31'd0, half_last_o}, 32'd0);
        exp_q.delete();
        exp_short_cnt = 0;
        exp_long_cnt  = 0;
        @(posedge clk_i);
        #1;
        rst_i        = 1'b0;
        half_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        check("t5_idle_ready", {31'd0, word_ready_o}, 32'd1);
        check("t5_idle_valid", {31'd0, half_valid_o}, 32'd0);
        send_word(32'hFFFF_FFFE, 1'b1);
        drain();

`ifdef SIGN_COMPRESS_STATS_EN
        send_word(32'h0000_0001, 1'b1);
        send_word(32'h0001_0000, 1'b0);
        send_word(32'hFFFF_FFF0, 1'b1);
        send_word(32'h7FFF_FFFF, 1'b0);
        drain();
        check("t6_cnt_short", {16'd0, cnt_short_o}, exp_short_cnt);
        check("t6_cnt_long", {16'd0, cnt_long_o}, exp_long_cnt);
        dut.cnt_short_q = 16'hFFFF;
        send_word(32'h0000_0042, 1'b1);
        drain();
        check("t6_cnt_short_wrap", {16'd0, cnt_short_o}, 32'd0);
`endif

        repeat (2) @(posedge clk_i);
        check("final_queue_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
